// File: rtl/ps2_paddle_ctrl.sv
// PS/2 keyboard receiver that turns W/S and the Up/Down arrow keys into
// paddle move commands for a two-player game.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, a frame must
// carry odd parity over data+parity bits; otherwise only the stop bit counts.
module ps2_paddle_ctrl #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_err,
    output logic       left_up,
    output logic       left_down,
    output logic       right_up,
    output logic       right_down
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    state_t        next_state;
    logic          clk_meta, clk_sync, clk_prev;
    logic          dat_meta, dat_sync;
    logic          ps2_fall;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          frame_ok;
    logic          accept;
    logic          reject;

    logic          ext, brk;
    logic [3:0]    held;
    logic          l_up_last, r_up_last;
    logic          nxt_ext, nxt_brk;
    logic [3:0]    nxt_held;
    logic          nxt_l_up_last, nxt_r_up_last;

    // Bring both PS/2 lines into the clock domain; keep one extra clock stage for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync;

    // Cycles since the last PS/2 falling edge; saturates so it never wraps back to zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (ps2_fall || state == IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !ps2_fall && (to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    // Capture the parity bit so the stop-bit edge can judge the whole frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (ps2_fall && state == PARITY) begin
            parity_bit <= dat_sync;
        end
    end

    assign frame_ok = dat_sync & (^{shift_reg, parity_bit});
`else
    assign frame_ok = dat_sync;
`endif

    // Frame FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame FSM next state: advance one step per PS/2 falling edge, bail out on timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (ps2_fall && !dat_sync)        next_state = DATA;
            DATA:   if (ps2_fall && bit_cnt == 3'd7)  next_state = PARITY;
            PARITY: if (ps2_fall)                     next_state = STOP;
            STOP:   if (ps2_fall)                     next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
        if (timeout) begin
            next_state = IDLE;
        end
    end

    // Frame FSM outputs: verdict on the stop-bit edge, or a rejection when the frame stalls
    always_comb begin
        accept = 1'b0;
        reject = timeout;
        if (state == STOP && ps2_fall) begin
            accept = frame_ok;
            reject = !frame_ok;
        end
    end

    // Shift data bits in LSB first and count them; a stalled frame throws its partial byte away
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (timeout) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (ps2_fall) begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shift_reg <= {dat_sync, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Publish the received byte and the one-cycle accept/reject pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scancode   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= reject;
            if (accept) begin
                scancode <= shift_reg;
            end
        end
    end

    // Key decoder: track E0/F0 prefixes, held keys and which direction was pressed most recently
    always_comb begin
        nxt_ext       = ext;
        nxt_brk       = brk;
        nxt_held      = held;
        nxt_l_up_last = l_up_last;
        nxt_r_up_last = r_up_last;
        if (frame_err) begin
            nxt_ext = 1'b0;
            nxt_brk = 1'b0;
        end else if (code_valid) begin
            if (scancode == CODE_EXT) begin
                nxt_ext = 1'b1;
            end else if (scancode == CODE_BRK) begin
                nxt_brk = 1'b1;
            end else begin
                nxt_ext = 1'b0;
                nxt_brk = 1'b0;
                if (!ext && scancode == KEY_W) begin
                    nxt_held[0] = !brk;
                    if (!brk && !held[0]) nxt_l_up_last = 1'b1;
                end else if (!ext && scancode == KEY_S) begin
                    nxt_held[1] = !brk;
                    if (!brk && !held[1]) nxt_l_up_last = 1'b0;
                end else if (ext && scancode == KEY_UP) begin
                    nxt_held[2] = !brk;
                    if (!brk && !held[2]) nxt_r_up_last = 1'b1;
                end else if (ext && scancode == KEY_DOWN) begin
                    nxt_held[3] = !brk;
                    if (!brk && !held[3]) nxt_r_up_last = 1'b0;
                end
            end
        end
    end

    // Register decoder state and the paddle commands, newest press winning when both are held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            held       <= '0;
            l_up_last  <= 1'b0;
            r_up_last  <= 1'b0;
            left_up    <= 1'b0;
            left_down  <= 1'b0;
            right_up   <= 1'b0;
            right_down <= 1'b0;
        end else begin
            ext        <= nxt_ext;
            brk        <= nxt_brk;
            held       <= nxt_held;
            l_up_last  <= nxt_l_up_last;
            r_up_last  <= nxt_r_up_last;
            left_up    <= nxt_held[0] & (~nxt_held[1] |  nxt_l_up_last);
            left_down  <= nxt_held[1] & (~nxt_held[0] | ~nxt_l_up_last);
            right_up   <= nxt_held[2] & (~nxt_held[3] |  nxt_r_up_last);
            right_down <= nxt_held[3] & (~nxt_held[2] | ~nxt_r_up_last);
        end
    end

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Self-checking bench for ps2_paddle_ctrl: directed scenarios plus randomized
// frames against a key-press model. Honours PS2_PARITY_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_ps2_paddle_ctrl;

    localparam int TO   = 200;
    localparam int HALF = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scancode;
    logic       code_valid;
    logic       frame_err;
    logic       left_up, left_down, right_up, right_down;

    int n_checks = 0;
    int n_fail   = 0;
    int cv_count = 0;
    int fe_count = 0;

    // Reference model: held keys with press timestamps (0 LU, 1 LD, 2 RU, 3 RD)
    bit         m_ext, m_brk;
    bit         m_held [4];
    int         m_stamp[4];
    int         m_ctr;
    logic [7:0] m_sc;

    ps2_paddle_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .scancode   (scancode),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .left_up    (left_up),
        .left_down  (left_down),
        .right_up   (right_up),
        .right_down (right_down)
    );

    always #5 clock = ~clock;

    // Count result pulses
    always @(negedge clock) begin
        if (code_valid) cv_count++;
        if (frame_err)  fe_count++;
    end

    // Watchdog so the run can never hang
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_ctr = 0; m_sc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            m_held[k] = 0;
            m_stamp[k] = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            k = -1;
            if (!m_ext && b == 8'h1D) k = 0;
            if (!m_ext && b == 8'h1B) k = 1;
            if (m_ext && b == 8'h75)  k = 2;
            if (m_ext && b == 8'h72)  k = 3;
            if (k >= 0) begin
                if (!m_brk) begin
                    if (!m_held[k]) begin
                        m_ctr++;
                        m_stamp[k] = m_ctr;
                        m_held[k] = 1;
                    end
                end else begin
                    m_held[k] = 0;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic logic exp_out(input int k);
        int o;
        o = k ^ 1;
        return m_held[k] && (!m_held[o] || m_stamp[k] > m_stamp[o]);
    endfunction

    function automatic bit frame_accepted(input bit par_ok, input bit stop_bit);
`ifdef PS2_PARITY_CHECK_EN
        return stop_bit && par_ok;
`else
        return stop_bit;
`endif
    endfunction

    task automatic drive_bit(input logic v);
        ps2_dat = v;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_ok, input bit stop_bit);
        logic par;
        par = par_ok ? ~(^b) : (^b);
        return {stop_bit, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_bit);
        logic [10:0] bits;
        bits = frame_bits(b, par_ok, stop_bit);
        for (int i = 0; i < 11; i++) drive_bit(bits[i]);
        ps2_dat = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic send_modeled(input logic [7:0] b, input bit par_ok, input bit stop_bit);
        send_frame(b, par_ok, stop_bit);
        if (frame_accepted(par_ok, stop_bit)) begin
            m_sc = b;
            model_byte(b);
        end else begin
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if (scancode !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_scancode: got %h want 00", scancode);
        end
        n_checks++;
        if ({code_valid, frame_err} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_pulses: got %b want 00", {code_valid, frame_err});
        end
        n_checks++;
        if ({left_up, left_down, right_up, right_down} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_paddles: got %b want 0000", {left_up, left_down, right_up, right_down});
        end
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
    endtask

    task automatic test_first_frame();
        logic [10:0] bits;
        int  cv0;
        bit  found;
        cv0 = cv_count;
        bits = frame_bits(8'h1D, 1, 1);
        for (int i = 0; i < 10; i++) drive_bit(bits[i]);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (code_valid) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("[TB] FAIL first_cv_pulse: got none want pulse within 10 cycles");
        end else begin
            n_checks++;
            if (scancode !== 8'h1D) begin
                n_fail++; $display("[TB] FAIL first_scancode: got %h want 1d", scancode);
            end
            n_checks++;
            if (left_up !== 1'b0) begin
                n_fail++; $display("[TB] FAIL first_lu_early: got %b want 0", left_up);
            end
            @(negedge clock);
            n_checks++;
            if ({left_up, code_valid} !== 2'b10) begin
                n_fail++; $display("[TB] FAIL first_lu_latency: got lu,cv=%b want 10", {left_up, code_valid});
            end
        end
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clock);
        m_sc = 8'h1D;
        model_byte(8'h1D);
        n_checks++;
        if (cv_count - cv0 !== 1) begin
            n_fail++; $display("[TB] FAIL first_cv_count: got %0d want 1", cv_count - cv0);
        end
    endtask

    task automatic test_left_paddle();
        logic [7:0] seq [4];
        seq = '{8'h1B, 8'h1D, 8'hF0, 8'h1B};
        for (int i = 0; i < 4; i++) begin
            send_modeled(seq[i], 1, 1);
            n_checks++;
            if ({left_up, left_down} !== {exp_out(0), exp_out(1)}) begin
                n_fail++;
                $display("[TB] FAIL left_seq%0d: got up,down=%b%b want %b%b", i, left_up, left_down, exp_out(0), exp_out(1));
            end
        end
        n_checks++;
        if ({left_up, left_down} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL left_after_break: got %b want 10", {left_up, left_down});
        end
        send_modeled(8'hF0, 1, 1);
        send_modeled(8'h1D, 1, 1);
        n_checks++;
        if ({left_up, left_down} !== 2'b00) begin
            n_fail++; $display("[TB] FAIL left_released: got %b want 00", {left_up, left_down});
        end
    endtask

    task automatic test_right_paddle();
        send_modeled(8'hE0, 1, 1);
        send_modeled(8'h75, 1, 1);
        n_checks++;
        if ({right_up, right_down, left_up, left_down} !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL right_press: got %b want 1000", {right_up, right_down, left_up, left_down});
        end
        send_modeled(8'hE0, 1, 1);
        send_modeled(8'hF0, 1, 1);
        send_modeled(8'h75, 1, 1);
        n_checks++;
        if ({right_up, right_down, left_up, left_down} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL right_release: got %b want 0000", {right_up, right_down, left_up, left_down});
        end
    endtask

    task automatic test_parity();
        int cv0, fe0;
        send_modeled(8'h1B, 1, 1);
        cv0 = cv_count; fe0 = fe_count;
        send_modeled(8'h1D, 0, 1);
        n_checks++;
        if ((cv_count - cv0) !== (frame_accepted(0, 1) ? 1 : 0)) begin
            n_fail++; $display("[TB] FAIL parity_cv: got %0d want %0d", cv_count - cv0, frame_accepted(0, 1) ? 1 : 0);
        end
        n_checks++;
        if ((fe_count - fe0) !== (frame_accepted(0, 1) ? 0 : 1)) begin
            n_fail++; $display("[TB] FAIL parity_fe: got %0d want %0d", fe_count - fe0, frame_accepted(0, 1) ? 0 : 1);
        end
        n_checks++;
        if (scancode !== m_sc) begin
            n_fail++; $display("[TB] FAIL parity_scancode: got %h want %h", scancode, m_sc);
        end
        n_checks++;
        if ({left_up, left_down} !== {exp_out(0), exp_out(1)}) begin
            n_fail++; $display("[TB] FAIL parity_paddle: got %b%b want %b%b", left_up, left_down, exp_out(0), exp_out(1));
        end
        send_modeled(8'hF0, 1, 1);
        send_modeled(8'h1D, 1, 1);
        send_modeled(8'hF0, 1, 1);
        send_modeled(8'h1B, 1, 1);
    endtask

    task automatic test_timeout();
        int cv0, fe0;
        cv0 = cv_count; fe0 = fe_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        ps2_dat = 1'b1;
        repeat (150) @(negedge clock);
        n_checks++;
        if (fe_count - fe0 !== 0) begin
            n_fail++; $display("[TB] FAIL timeout_early: got %0d frame_err want 0", fe_count - fe0);
        end
        repeat (150) @(negedge clock);
        m_ext = 0; m_brk = 0;
        n_checks++;
        if (fe_count - fe0 !== 1 || cv_count - cv0 !== 0) begin
            n_fail++; $display("[TB] FAIL timeout_pulse: got fe=%0d cv=%0d want fe=1 cv=0", fe_count - fe0, cv_count - cv0);
        end
        cv0 = cv_count;
        send_modeled(8'h1D, 1, 1);
        n_checks++;
        if (cv_count - cv0 !== 1 || scancode !== 8'h1D) begin
            n_fail++; $display("[TB] FAIL timeout_recover: got cv=%0d sc=%h want cv=1 sc=1d", cv_count - cv0, scancode);
        end
        n_checks++;
        if (left_up !== exp_out(0)) begin
            n_fail++; $display("[TB] FAIL timeout_lu: got %b want %b", left_up, exp_out(0));
        end
    endtask

    task automatic test_reset_mid_frame();
        int cv0, fe0;
        send_modeled(8'h1D, 1, 1);
        n_checks++;
        if (left_up !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midrst_held: got %b want 1", left_up);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({scancode, code_valid, frame_err, left_up, left_down, right_up, right_down} !== 14'd0) begin
            n_fail++; $display("[TB] FAIL midrst_outputs: got sc=%h lu=%b ld=%b want all 0", scancode, left_up, left_down);
        end
        reset = 1'b0;
        model_reset();
        cv0 = cv_count; fe0 = fe_count;
        repeat (TO + 100) @(negedge clock);
        n_checks++;
        if (cv_count - cv0 !== 0 || fe_count - fe0 !== 0) begin
            n_fail++; $display("[TB] FAIL midrst_pulses: got cv=%0d fe=%0d want 0 0", cv_count - cv0, fe_count - fe0);
        end
        send_modeled(8'h1B, 1, 1);
        n_checks++;
        if ({left_up, left_down} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL midrst_next: got %b want 01", {left_up, left_down});
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit par_ok, stop_bit, acc;
        int cv0, fe0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h1D;
                3: b = 8'h1B;
                4: b = 8'h75;
                5: b = 8'h72;
                default: b = 8'($urandom_range(0, 255));
            endcase
            stop_bit = ($urandom_range(0, 9) != 0);
            par_ok   = ($urandom_range(0, 4) != 0);
            acc = frame_accepted(par_ok, stop_bit);
            cv0 = cv_count; fe0 = fe_count;
            send_modeled(b, par_ok, stop_bit);
            n_checks++;
            if (cv_count - cv0 !== (acc ? 1 : 0) || fe_count - fe0 !== (acc ? 0 : 1)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_pulses: byte %h got cv=%0d fe=%0d want cv=%0d fe=%0d", n, b, cv_count - cv0, fe_count - fe0, acc ? 1 : 0, acc ? 0 : 1);
            end
            n_checks++;
            if (scancode !== m_sc) begin
                n_fail++; $display("[TB] FAIL rand%0d_scancode: got %h want %h", n, scancode, m_sc);
            end
            n_checks++;
            if ({left_up, left_down, right_up, right_down} !== {exp_out(0), exp_out(1), exp_out(2), exp_out(3)}) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_paddles: got %b%b%b%b want %b%b%b%b", n, left_up, left_down, right_up, right_down,
                         exp_out(0), exp_out(1), exp_out(2), exp_out(3));
            end
            n_checks++;
            if ((left_up && left_down) || (right_up && right_down)) begin
                n_fail++; $display("[TB] FAIL rand%0d_exclusive: got %b%b%b%b want no up+down pair", n, left_up, left_down, right_up, right_down);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_left_paddle();
        test_right_paddle();
        test_parity();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
